// File: rtl/alu32.sv
// alu32: registered 32-bit ALU (AND, OR, ADD, SUB, signed SLT) with overflow/carry/zero flags.
module alu32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero
);
    localparam int M = DATA_WIDTH - 1;
    logic              sub, ovf, lt, arith, ovf_d, cout_d;
    logic              ovf_q, cout_q, zero_q;
    logic [M:0]        b_eff, sum, result_d, result_q;
    logic [DATA_WIDTH:0] sum_full;
    // One adder for ADD/SUB/SLT: ALUop[2] inverts B and supplies the carry-in.
    always_comb begin
        sub      = ALUop[2];
        b_eff    = sub ? ~B : B;
        sum_full = {1'b0, A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
        sum      = sum_full[M:0];
        ovf      = (A[M] == b_eff[M]) && (sum[M] != A[M]);
        lt       = sum[M] ^ ovf;
        arith    = (ALUop == 3'b010) || (ALUop == 3'b110);
        result_d = ALUop == 3'b000 ? A & B :
                   ALUop == 3'b001 ? A | B :
                   arith           ? sum :
                   ALUop == 3'b111 ? {{M{1'b0}}, lt} : '0;
        ovf_d    = arith && ovf;
        cout_d   = ALUop == 3'b010 ? sum_full[DATA_WIDTH] :
                   ALUop == 3'b110 ? ~sum_full[DATA_WIDTH] : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
            zero_q   <= ~|result_d;
        end
    end
    assign Result   = result_q;
    assign Overflow = ovf_q;
    assign CarryOut = cout_q;
    assign Zero     = zero_q;
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: randomized and directed checks of alu32 against an arithmetic reference model.
module tb_alu32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A = '0, B = '0, Result;
    logic [2:0]  ALUop = '0;
    logic        Overflow, CarryOut, Zero;
    int          vectors = 0, errors = 0;

    alu32 #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .ALUop(ALUop),
        .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero)
    );

    always #5 clk = ~clk;

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      s;
        logic [31:0] r = '0;
        logic        ov = 1'b0, co = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                r  = a + b;
                s  = sa + sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                co = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
            end
            3'b110: begin
                r  = a - b;
                s  = sa - sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                co = a < b;
            end
            3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {r, ov, co, r == 32'd0};
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUop = op; A = a; B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(3'($urandom), $urandom, $urandom);
            vectors++;
            if ({Result, Overflow, CarryOut, Zero} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset[%0d] got %h,%b,%b,%b exp 00000000,0,0,1", i, Result, Overflow, CarryOut, Zero);
            end
        end
        rst = 1'b0;
        issue(3'b001, 32'h1, 32'h0);
        vectors++;
        if ({Result, Zero} !== {32'h1, 1'b0}) begin
            errors++;
            $display("FAIL reset_release got %h,%b exp 00000001,0", Result, Zero);
        end
        // ADD producing non-zero flags issued while reset is asserted must be discarded.
        rst = 1'b1;
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
        vectors++;
        if ({Result, Overflow, CarryOut, Zero} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_midstream got %h,%b,%b,%b exp 00000000,0,0,1", Result, Overflow, CarryOut, Zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_and_or;
        logic [101:0] t [4];
        t = '{{3'b000, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1},
              {3'b000, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0},
              {3'b001, 32'h0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0},
              {3'b001, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1}};
        foreach (t[i]) begin
            issue(t[i][101:99], t[i][98:67], t[i][66:35]);
            vectors++;
            if ({Result, Overflow, CarryOut, Zero} !== t[i][34:0]) begin
                errors++;
                $display("FAIL and_or[%0d] got %h,%b,%b,%b exp %h", i, Result, Overflow, CarryOut, Zero, t[i][34:0]);
            end
        end
    endtask

    task automatic test_add_sub;
        logic [101:0] t [5];
        t = '{{3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0},
              {3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0},
              {3'b110, 32'h7FFFFFFF, 32'h7FFFFFFD, 32'h00000002, 1'b0, 1'b0, 1'b0},
              {3'b110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0},
              {3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1}};
        foreach (t[i]) begin
            issue(t[i][101:99], t[i][98:67], t[i][66:35]);
            vectors++;
            if ({Result, Overflow, CarryOut, Zero} !== t[i][34:0]) begin
                errors++;
                $display("FAIL add_sub[%0d] got %h,%b,%b,%b exp %h", i, Result, Overflow, CarryOut, Zero, t[i][34:0]);
            end
        end
    endtask

    task automatic test_slt_reserved;
        logic [101:0] t [6];
        t = '{{3'b111, 32'h00000000, 32'h00000001, 32'h1, 1'b0, 1'b0, 1'b0},
              {3'b111, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0},
              {3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1},
              {3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1},
              {3'b100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1},
              {3'b101, 32'hDEADBEEF, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b1}};
        foreach (t[i]) begin
            issue(t[i][101:99], t[i][98:67], t[i][66:35]);
            vectors++;
            if ({Result, Overflow, CarryOut, Zero} !== t[i][34:0]) begin
                errors++;
                $display("FAIL slt_reserved[%0d] got %h,%b,%b,%b exp %h", i, Result, Overflow, CarryOut, Zero, t[i][34:0]);
            end
        end
    endtask

    // New op every cycle; outputs must hold mid-cycle and update exactly one edge later.
    task automatic test_back_to_back;
        logic [31:0] edges [4] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [34:0] prev, exp;
        logic [31:0] a, b;
        logic [2:0]  op;
        prev = {Result, Overflow, CarryOut, Zero};
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom);
            a  = ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom;
            b  = ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom;
            if (i % 7 == 0) b = a;
            exp = model(op, a, b);
            ALUop = op; A = a; B = b;
            @(negedge clk);
            vectors++;
            if ({Result, Overflow, CarryOut, Zero} !== prev) begin
                errors++;
                $display("FAIL hold[%0d] got %h exp %h", i, {Result, Overflow, CarryOut, Zero}, prev);
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({Result, Overflow, CarryOut, Zero} !== exp) begin
                errors++;
                $display("FAIL random[%0d] op=%b a=%h b=%h got %h,%b,%b,%b exp %h", i, op, a, b,
                         Result, Overflow, CarryOut, Zero, exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        test_reset();
        test_and_or();
        test_add_sub();
        test_slt_reserved();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
